// File: rtl/seg_pkg.sv
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants for the seven-segment scan controller.
//                Holds the active-low hex decode table (bit7 = dp, bits6:0 =
//                segments g..a) and the two special segment patterns.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    // Segment pattern with every segment and the dp dark.
    localparam logic [7:0] SEG_OFF     = 8'hFF;
    // Only the decimal point lit (used for suppressed digits that keep dp).
    localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

    // Active-low hex glyphs, entry k is the pattern for nibble k.
    // Bit7 (dp) is set in every entry; the decoder clears it when dp is lit.
    localparam logic [15:0][7:0] SEG_HEX_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage : seg_pkg

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// ============================================================================
//  Module      : seg_scan_ctrl_if
//  Description : Bundle of the display-content inputs and the multiplexed
//                display outputs of seg_scan_ctrl.
//                  in_data     4*NUM_DIGITS  hex nibbles, nibble k = digit k
//                  in_dp       NUM_DIGITS    decimal point request, 1 = lit
//                  in_blank    NUM_DIGITS    force-blank, 1 = dark
//                  in_blink    NUM_DIGITS    blink enable
//                  in_lzs      1             leading-zero suppression enable
//                  load        1             capture strobe for all in_*
//                  segment_led 8             active-low segments (bit7 = dp)
//                  seg_en      NUM_DIGITS    active-low one-hot digit enable
//                  frame_done  1             pulse per completed scan frame
//                master : the content source / display observer
//                slave  : the scan controller
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
) ();

    logic [4*NUM_DIGITS-1:0] in_data;
    logic [NUM_DIGITS-1:0]   in_dp;
    logic [NUM_DIGITS-1:0]   in_blank;
    logic [NUM_DIGITS-1:0]   in_blink;
    logic                    in_lzs;
    logic                    load;
    logic [7:0]              segment_led;
    logic [NUM_DIGITS-1:0]   seg_en;
    logic                    frame_done;

    modport master (
        output in_data, in_dp, in_blank, in_blink, in_lzs, load,
        input  segment_led, seg_en, frame_done
    );

    modport slave (
        input  in_data, in_dp, in_blank, in_blink, in_lzs, load,
        output segment_led, seg_en, frame_done
    );

endinterface : seg_scan_ctrl_if

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
//  Module      : seg_hex_decode
//  Description : Combinational hex-to-seven-segment decoder, active-low.
//                  nibble  in  4  hex value to show
//                  dp      in  1  1 = decimal point lit
//                  pattern out 8  bit7 = dp, bits6:0 = g..a (0 = lit)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    // Table entries carry bit7 = 1, so masking bit7 with ~dp lights the dp.
    assign pattern = SEG_HEX_TABLE[nibble] & {~dp, 7'h7F};

endmodule : seg_hex_decode

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Multiplexed seven-segment display scanner. Scans digits
//                MSD first, one digit per SCAN_DIV-cycle slot, with the first
//                cycle of every slot dark to avoid ghosting. New content is
//                double-buffered and only takes effect at a frame boundary.
//                Supports per-digit blank/blink/dp and leading-zero
//                suppression.
//                  clk   in  1   system clock, rising edge
//                  rst   in  1   asynchronous reset, active-high
//                  bus   slave modport of seg_scan_ctrl_if
//                Parameters: NUM_DIGITS 1..8, SCAN_DIV >= 2,
//                BLINK_FRAMES >= 1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0]  C_PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] C_FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    // Scan timing
    logic [PRE_W-1:0]        r_pre;
    logic [IDX_W-1:0]        r_idx;
    logic [FCNT_W-1:0]       r_fcnt;
    logic                    r_phase;

    // Pending (written by load) and active (displayed) content
    logic [4*NUM_DIGITS-1:0] r_pend_data,  r_act_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;
    logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;
    logic                    r_pend_lzs,   r_act_lzs;
    logic                    r_pend_valid;

    // Registered outputs
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_en;
    logic                    r_frame_done;

    logic                    w_tc;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic [7:0]              w_dec;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_en_next;

    assign w_tc   = (r_pre == C_PRE_LAST);
    assign w_wrap = w_tc && (r_idx == '0);

    // Digit k>0 is suppressed while every nibble from the MSD down to k is 0.
    always_comb begin
        w_supp     = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_act_data[4*k +: 4] == 4'h0);
            w_supp[k]  = r_act_lzs && w_zero_run;
        end
    end

    assign w_nib = r_act_data[{r_idx, 2'b00} +: 4];
    assign w_dp  = r_act_dp[r_idx];
    assign w_sel = ~(NUM_DIGITS'(1) << r_idx);

    seg_hex_decode u_decode (
        .nibble  (w_nib),
        .dp      (w_dp),
        .pattern (w_dec)
    );

    always_comb begin
        w_seg_next = SEG_OFF;
        w_en_next  = '1;
        if (r_act_blank[r_idx] || (r_phase && r_act_blink[r_idx])) begin
            w_seg_next = SEG_OFF;
            w_en_next  = '1;
        end else if (w_supp[r_idx]) begin
            if (r_act_dp[r_idx]) begin
                w_seg_next = SEG_DP_ONLY;
                w_en_next  = w_sel;
            end
        end else begin
            w_seg_next = w_dec;
            w_en_next  = w_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre        <= '0;
            r_idx        <= C_IDX_LAST;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_blink <= '0;
            r_pend_lzs   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_act_blink  <= '0;
            r_act_lzs    <= 1'b0;
            r_seg        <= SEG_OFF;
            r_en         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_pre <= w_tc ? '0 : r_pre + PRE_W'(1);

            if (w_tc) begin
                r_idx <= (r_idx == '0) ? C_IDX_LAST : r_idx - IDX_W'(1);
            end

            // Content only reaches the active set at the frame boundary. A
            // load landing exactly on the boundary is the newest data, so it
            // bypasses pending.
            if (w_wrap) begin
                if (bus.load) begin
                    r_act_data  <= bus.in_data;
                    r_act_dp    <= bus.in_dp;
                    r_act_blank <= bus.in_blank;
                    r_act_blink <= bus.in_blink;
                    r_act_lzs   <= bus.in_lzs;
                end else if (r_pend_valid) begin
                    r_act_data  <= r_pend_data;
                    r_act_dp    <= r_pend_dp;
                    r_act_blank <= r_pend_blank;
                    r_act_blink <= r_pend_blink;
                    r_act_lzs   <= r_pend_lzs;
                end
                r_pend_valid <= 1'b0;
            end else if (bus.load) begin
                r_pend_data  <= bus.in_data;
                r_pend_dp    <= bus.in_dp;
                r_pend_blank <= bus.in_blank;
                r_pend_blink <= bus.in_blink;
                r_pend_lzs   <= bus.in_lzs;
                r_pend_valid <= 1'b1;
            end

            if (w_wrap) begin
                if (r_fcnt == C_FCNT_LAST) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end

            r_frame_done <= w_wrap;

            // The slot following a terminal count opens with a dark cycle.
            r_seg <= w_tc ? SEG_OFF : w_seg_next;
            r_en  <= w_tc ? '1      : w_en_next;
        end
    end

    assign bus.segment_led = r_seg;
    assign bus.seg_en      = r_en;
    assign bus.frame_done  = r_frame_done;

endmodule : seg_scan_ctrl

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl (8 digits, SCAN_DIV 4,
//                BLINK_FRAMES 2). A timeline model derives the expected
//                display from the cycle count since reset release.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int N     = 8;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [7:0]  blink;
        logic        lzs;
    } disp_t;

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] exp_seg;
    } vec_t;

    int    n_checks = 0;
    int    n_err    = 0;

    // Model state: cycles since reset release, active and pending content.
    int    t = 0;
    disp_t m_act, m_pend;
    bit    m_pv;

    int         last_t;
    logic [7:0] last_seg, last_en;
    logic       last_fd;

    function automatic logic [7:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic int digit_of(input int tt);
        return N - 1 - ((tt / SD) % N);
    endfunction

    task automatic model_expect(output logic [7:0] seg, output logic [7:0] en, output logic fd);
        int  p, d, f;
        bit  dark, supp;
        p   = t % SD;
        fd  = (p == 0) && (t > 0) && ((t % FRAME) == 0);
        seg = 8'hFF;
        en  = 8'hFF;
        if (p != 0) begin
            d    = digit_of(t);
            f    = t / FRAME;
            dark = m_act.blank[d] || ((((f / BF) % 2) == 1) && m_act.blink[d]);
            supp = 1'b0;
            if (m_act.lzs && d > 0) begin
                supp = 1'b1;
                for (int j = d; j < N; j++)
                    if (m_act.data[4*j +: 4] != 4'h0) supp = 1'b0;
            end
            if (dark) begin
                seg = 8'hFF;
            end else if (supp) begin
                if (m_act.dp[d]) begin
                    seg = 8'h7F;
                    en  = ~(8'h01 << d);
                end
            end else begin
                seg = hex_pat(m_act.data[4*d +: 4]);
                if (m_act.dp[d]) seg[7] = 1'b0;
                en  = ~(8'h01 << d);
            end
        end
    endtask

    task automatic model_update();
        disp_t cur;
        cur = {bus.in_data, bus.in_dp, bus.in_blank, bus.in_blink, bus.in_lzs};
        if (((t + 1) % FRAME) == 0) begin
            if (bus.load)  m_act = cur;
            else if (m_pv) m_act = m_pend;
            m_pv = 1'b0;
        end else if (bus.load) begin
            m_pend = cur;
            m_pv   = 1'b1;
        end
        t++;
    endtask

    task automatic model_reset();
        t      = 0;
        m_act  = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance it.
    task automatic cycle();
        logic [7:0] es, ee;
        logic       ef;
        @(negedge clk);
        model_expect(es, ee, ef);
        last_t   = t;
        last_seg = bus.segment_led;
        last_en  = bus.seg_en;
        last_fd  = bus.frame_done;
        check8("segment_led", last_seg, es);
        check8("seg_en", last_en, ee);
        check8("frame_done", {7'd0, last_fd}, {7'd0, ef});
        @(posedge clk);
        model_update();
        #1;
        bus.load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance to the first lit cycle of digit d's slot.
    task automatic wait_slot(input int d, output bit found);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle();
            if ((last_t % SD) == 1 && digit_of(last_t) == d) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_slot digit=%0d actual=timeout required=reached", d);
        end
    endtask

    task automatic slot_check(input string name, input int d, input logic [7:0] es, input logic [7:0] ee);
        bit found;
        wait_slot(d, found);
        if (found) begin
            check8({name, "_seg"}, last_seg, es);
            check8({name, "_en"}, last_en, ee);
        end
    endtask

    task automatic load_content(input logic [31:0] data, input logic [7:0] dp,
                                input logic [7:0] blank, input logic [7:0] blink, input logic lzs);
        bus.in_data  = data;
        bus.in_dp    = dp;
        bus.in_blank = blank;
        bus.in_blink = blink;
        bus.in_lzs   = lzs;
        bus.load     = 1'b1;
        cycle();
    endtask

    vec_t       vecs [16];
    logic [7:0] pat36 [8];
    bit         found;
    bit         lit [8];
    int         fd_cnt, lit_cnt;

    initial begin
        vecs[0]  = '{4'h0, 1'b0, 8'hC0};  vecs[1]  = '{4'h1, 1'b0, 8'hF9};
        vecs[2]  = '{4'h2, 1'b0, 8'hA4};  vecs[3]  = '{4'h3, 1'b1, 8'h30};
        vecs[4]  = '{4'h4, 1'b0, 8'h99};  vecs[5]  = '{4'h5, 1'b0, 8'h92};
        vecs[6]  = '{4'h6, 1'b0, 8'h82};  vecs[7]  = '{4'h7, 1'b1, 8'h78};
        vecs[8]  = '{4'h8, 1'b0, 8'h80};  vecs[9]  = '{4'h9, 1'b0, 8'h90};
        vecs[10] = '{4'hA, 1'b0, 8'h88};  vecs[11] = '{4'hB, 1'b1, 8'h03};
        vecs[12] = '{4'hC, 1'b0, 8'hC6};  vecs[13] = '{4'hD, 1'b0, 8'hA1};
        vecs[14] = '{4'hE, 1'b0, 8'h86};  vecs[15] = '{4'hF, 1'b1, 8'h0E};
        pat36[7] = 8'hF9; pat36[6] = 8'hA4; pat36[5] = 8'hB0; pat36[4] = 8'h99;
        pat36[3] = 8'h88; pat36[2] = 8'h83; pat36[1] = 8'hC6; pat36[0] = 8'hA1;

        bus.in_data  = '0;
        bus.in_dp    = '0;
        bus.in_blank = '0;
        bus.in_blink = '0;
        bus.in_lzs   = 1'b0;
        bus.load     = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check8("reset_seg", bus.segment_led, 8'hFF);
        check8("reset_en", bus.seg_en, 8'hFF);
        check8("reset_fd", {7'd0, bus.frame_done}, 8'h00);
        rst = 1'b0;
        model_reset();
        slot_check("first_msd", 7, 8'hC0, 8'h7F);
        check_int("first_msd_time", last_t, 1);

        // Decode table through digit 0
        for (int i = 0; i < 16; i++) begin
            load_content({8{vecs[i].nib}}, vecs[i].dp ? 8'hFF : 8'h00, 8'h00, 8'h00, 1'b0);
            run(2 * FRAME);
            slot_check("decode", 0, vecs[i].exp_seg, 8'hFE);
        end

        // Full frame of mixed glyphs, MSD first
        load_content(32'h1234ABCD, 8'h00, 8'h00, 8'h00, 1'b0);
        run(2 * FRAME);
        for (int d = N - 1; d >= 0; d--)
            slot_check("frame_glyph", d, pat36[d], ~(8'h01 << d));

        // Leading-zero suppression, then dp on a suppressed digit
        load_content(32'h00000050, 8'h00, 8'h00, 8'h00, 1'b1);
        run(2 * FRAME);
        slot_check("lzs_d4_dark", 4, 8'hFF, 8'hFF);
        slot_check("lzs_d1", 1, 8'h92, 8'hFD);
        slot_check("lzs_d0_zero", 0, 8'hC0, 8'hFE);
        load_content(32'h00000050, 8'h10, 8'h00, 8'h00, 1'b1);
        run(2 * FRAME);
        slot_check("lzs_dp_only", 4, 8'h7F, 8'hEF);

        // Load mid-frame at digit 3: old data until the next MSD slot
        wait_slot(3, found);
        load_content(32'h11111111, 8'h00, 8'h00, 8'h00, 1'b0);
        slot_check("mid_old_d1", 1, 8'h92, 8'hFD);
        fd_cnt = 0;
        found  = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle();
            if (last_fd) fd_cnt++;
            if ((last_t % SD) == 1 && digit_of(last_t) == 7) found = 1'b1;
        end
        check_int("mid_fd_count", fd_cnt, 1);
        check8("mid_new_msd_seg", last_seg, 8'hF9);
        check8("mid_new_msd_en", last_en, 8'h7F);

        // Blink on digit 0: two frames lit, two dark
        load_content(32'h00000000, 8'h00, 8'h00, 8'h01, 1'b0);
        run(2 * FRAME);
        for (int f = 0; f < 8; f++) begin
            wait_slot(0, found);
            lit[f] = (last_seg != 8'hFF);
        end
        lit_cnt = 0;
        for (int f = 0; f < 8; f++) if (lit[f]) lit_cnt++;
        check_int("blink_lit_frames", lit_cnt, 4);
        for (int f = 0; f < 6; f++)
            check_int("blink_alternation", int'(lit[f] != lit[f+2]), 1);

        // Reset during digit 5 with a pending load outstanding
        load_content(32'h87654321, 8'h00, 8'h00, 8'h00, 1'b0);
        run(2 * FRAME);
        wait_slot(7, found);
        load_content(32'h11111111, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_slot(5, found);
        #2;
        rst = 1'b1;
        #1;
        check8("rst_async_seg", bus.segment_led, 8'hFF);
        check8("rst_async_en", bus.seg_en, 8'hFF);
        check8("rst_async_fd", {7'd0, bus.frame_done}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        slot_check("rst_restart_msd", 7, 8'hC0, 8'h7F);
        check_int("rst_restart_time", last_t, 1);

        // Randomized content and load timing
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_data  = $urandom >> (4 * $urandom_range(0, 8));
                bus.in_dp    = 8'($urandom);
                bus.in_blank = 8'($urandom & $urandom & $urandom);
                bus.in_blink = 8'($urandom & $urandom);
                bus.in_lzs   = 1'($urandom_range(0, 1));
            end
            if (((t + 1) % FRAME) == 0) bus.load = 1'($urandom_range(0, 1));
            else                        bus.load = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_seg_scan_ctrl

`default_nettype wire
